// File: rtl/mem_ctrl.sv
// Memory-side responder: arbitrates store/load/fetch requests and serialises
// each onto a byte-wide RAM port with one-cycle read latency.
module mem_ctrl #(
    parameter int RAM_ADDR_WIDTH = 32,
    parameter int FETCH_BYTES    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      in_lsb_ce,
    input  logic [5:0]                in_lsb_size,
    input  logic                      in_lsb_signed,
    input  logic [31:0]               in_lsb_addr,
    output logic                      out_lsb_ce,
    output logic [31:0]               out_lsb_data,
    input  logic                      in_rob_st_ce,
    input  logic [5:0]                in_rob_st_size,
    input  logic [31:0]               in_rob_st_addr,
    input  logic [31:0]               in_rob_st_data,
    output logic                      out_rob_st_done,
    input  logic                      in_fetcher_ce,
    input  logic [31:0]               in_fetcher_addr,
    output logic                      out_fetcher_ce,
    output logic [31:0]               out_fetcher_inst,
    input  logic                      in_rob_misbranch,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [RAM_ADDR_WIDTH-1:0] mem_a,
    output logic                      mem_wr,
    output logic [1:0]                dbg_state
);

    // Handshake: every *_ce / *_done is a single-cycle pulse with no backpressure;
    // a request pulse is accepted on the edge it is sampled (rdy=1) unless that
    // port already holds a pending request, and operands are valid with the pulse.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [2:0]  k, k_n, k_inc;
    logic [31:0] cur_addr, cur_addr_n;
    logic [31:0] cur_data, cur_data_n;
    logic [2:0]  cur_n, cur_n_n;
    logic        cur_sgn, cur_sgn_n;
    logic        cur_fetch, cur_fetch_n;
    logic [31:0] rbuf, rbuf_n, rword;

    logic        st_pend, st_pend_n;
    logic [31:0] st_addr, st_addr_n;
    logic [31:0] st_data, st_data_n;
    logic [2:0]  st_n, st_n_n;
    logic        ld_pend, ld_pend_n;
    logic [31:0] ld_addr, ld_addr_n;
    logic [2:0]  ld_n, ld_n_n;
    logic        ld_sgn, ld_sgn_n;
    logic        fe_pend, fe_pend_n;
    logic [31:0] fe_addr, fe_addr_n;

    logic                      lsb_ce_n, st_done_n, fe_ce_n, wr_n;
    logic [31:0]               lsb_data_n, fe_inst_n;
    logic [7:0]                dout_n;
    logic [RAM_ADDR_WIDTH-1:0] a_n;

    function automatic logic [2:0] size_to_n(input logic [5:0] s);
        case (s)
            6'd1:    return 3'd1;
            6'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                           input logic sgn);
        case (n)
            3'd1:    return {{24{sgn & w[7]}}, w[7:0]};
            3'd2:    return {{16{sgn & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [RAM_ADDR_WIDTH-1:0] ram_addr(input logic [31:0] base,
                                                            input logic [2:0] j);
        logic [31:0] s;
        s = base + {29'd0, j};
        return s[RAM_ADDR_WIDTH-1:0];
    endfunction

    assign dbg_state = state;

    always_comb begin
        state_n     = state;
        k_n         = k;
        k_inc       = k + 3'd1;
        cur_addr_n  = cur_addr;
        cur_data_n  = cur_data;
        cur_n_n     = cur_n;
        cur_sgn_n   = cur_sgn;
        cur_fetch_n = cur_fetch;
        rbuf_n      = rbuf;
        rword       = rbuf;
        st_pend_n   = st_pend;
        st_addr_n   = st_addr;
        st_data_n   = st_data;
        st_n_n      = st_n;
        ld_pend_n   = ld_pend;
        ld_addr_n   = ld_addr;
        ld_n_n      = ld_n;
        ld_sgn_n    = ld_sgn;
        fe_pend_n   = fe_pend;
        fe_addr_n   = fe_addr;
        lsb_ce_n    = 1'b0;
        st_done_n   = 1'b0;
        fe_ce_n     = 1'b0;
        lsb_data_n  = out_lsb_data;
        fe_inst_n   = out_fetcher_inst;
        dout_n      = mem_dout;
        a_n         = mem_a;
        wr_n        = mem_wr;

        // Capture new pulses first so IDLE can serve a same-edge pulse directly.
        if (in_rob_st_ce && !st_pend) begin
            st_pend_n = 1'b1;
            st_addr_n = in_rob_st_addr;
            st_data_n = in_rob_st_data;
            st_n_n    = size_to_n(in_rob_st_size);
        end
        if (in_lsb_ce && !ld_pend) begin
            ld_pend_n = 1'b1;
            ld_addr_n = in_lsb_addr;
            ld_n_n    = size_to_n(in_lsb_size);
            ld_sgn_n  = in_lsb_signed;
        end
        if (in_fetcher_ce && !fe_pend) begin
            fe_pend_n = 1'b1;
            fe_addr_n = in_fetcher_addr;
        end
        if (in_rob_misbranch) begin
            ld_pend_n = 1'b0;
            fe_pend_n = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (st_pend_n) begin
                    st_pend_n  = 1'b0;
                    cur_addr_n = st_addr_n;
                    cur_data_n = st_data_n;
                    cur_n_n    = st_n_n;
                    k_n        = 3'd0;
                    a_n        = ram_addr(st_addr_n, 3'd0);
                    dout_n     = st_data_n[7:0];
                    wr_n       = 1'b1;
                    state_n    = S_WRITE;
                end else if (ld_pend_n) begin
                    ld_pend_n   = 1'b0;
                    cur_addr_n  = ld_addr_n;
                    cur_n_n     = ld_n_n;
                    cur_sgn_n   = ld_sgn_n;
                    cur_fetch_n = 1'b0;
                    k_n         = 3'd0;
                    rbuf_n      = 32'd0;
                    a_n         = ram_addr(ld_addr_n, 3'd0);
                    wr_n        = 1'b0;
                    state_n     = S_READ;
                end else if (fe_pend_n) begin
                    fe_pend_n   = 1'b0;
                    cur_addr_n  = fe_addr_n;
                    cur_n_n     = 3'(FETCH_BYTES);
                    cur_sgn_n   = 1'b0;
                    cur_fetch_n = 1'b1;
                    k_n         = 3'd0;
                    rbuf_n      = 32'd0;
                    a_n         = ram_addr(fe_addr_n, 3'd0);
                    wr_n        = 1'b0;
                    state_n     = S_READ;
                end else begin
                    wr_n = 1'b0;
                end
            end
            S_READ: begin
                if (in_rob_misbranch) begin
                    state_n = S_IDLE;
                end else begin
                    // mem_din now holds the byte addressed one cycle earlier (lane k-1).
                    case (k)
                        3'd1:    rword[7:0]   = mem_din;
                        3'd2:    rword[15:8]  = mem_din;
                        3'd3:    rword[23:16] = mem_din;
                        3'd4:    rword[31:24] = mem_din;
                        default: rword        = rbuf;
                    endcase
                    rbuf_n = rword;
                    if (k_inc < cur_n) begin
                        a_n = ram_addr(cur_addr, k_inc);
                    end
                    if (k == cur_n) begin
                        state_n = S_DONE;
                        if (cur_fetch) begin
                            fe_ce_n   = 1'b1;
                            fe_inst_n = rword;
                        end else begin
                            lsb_ce_n   = 1'b1;
                            lsb_data_n = extend(rword, cur_n, cur_sgn);
                        end
                    end
                    k_n = k_inc;
                end
            end
            S_WRITE: begin
                if (k_inc < cur_n) begin
                    k_n    = k_inc;
                    a_n    = ram_addr(cur_addr, k_inc);
                    dout_n = 8'(cur_data >> {k_inc, 3'b000});
                end else begin
                    wr_n      = 1'b0;
                    st_done_n = 1'b1;
                    state_n   = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            k                <= 3'd0;
            cur_addr         <= 32'd0;
            cur_data         <= 32'd0;
            cur_n            <= 3'd0;
            cur_sgn          <= 1'b0;
            cur_fetch        <= 1'b0;
            rbuf             <= 32'd0;
            st_pend          <= 1'b0;
            st_addr          <= 32'd0;
            st_data          <= 32'd0;
            st_n             <= 3'd0;
            ld_pend          <= 1'b0;
            ld_addr          <= 32'd0;
            ld_n             <= 3'd0;
            ld_sgn           <= 1'b0;
            fe_pend          <= 1'b0;
            fe_addr          <= 32'd0;
            out_lsb_ce       <= 1'b0;
            out_lsb_data     <= 32'd0;
            out_rob_st_done  <= 1'b0;
            out_fetcher_ce   <= 1'b0;
            out_fetcher_inst <= 32'd0;
            mem_dout         <= 8'd0;
            mem_a            <= '0;
            mem_wr           <= 1'b0;
        end else if (rdy) begin
            state            <= state_n;
            k                <= k_n;
            cur_addr         <= cur_addr_n;
            cur_data         <= cur_data_n;
            cur_n            <= cur_n_n;
            cur_sgn          <= cur_sgn_n;
            cur_fetch        <= cur_fetch_n;
            rbuf             <= rbuf_n;
            st_pend          <= st_pend_n;
            st_addr          <= st_addr_n;
            st_data          <= st_data_n;
            st_n             <= st_n_n;
            ld_pend          <= ld_pend_n;
            ld_addr          <= ld_addr_n;
            ld_n             <= ld_n_n;
            ld_sgn           <= ld_sgn_n;
            fe_pend          <= fe_pend_n;
            fe_addr          <= fe_addr_n;
            out_lsb_ce       <= lsb_ce_n;
            out_lsb_data     <= lsb_data_n;
            out_rob_st_done  <= st_done_n;
            out_fetcher_ce   <= fe_ce_n;
            out_fetcher_inst <= fe_inst_n;
            mem_dout         <= dout_n;
            mem_a            <= a_n;
            mem_wr           <= wr_n;
        end
    end

endmodule
